// File: rtl/emu_scan_ctrl.sv
// Checkpoint sequencer: pauses the emulated DUT and streams its FF and RAM scan
// chains to the host (save) or from the host (load), one word per handshake beat.
module emu_scan_ctrl #(
  parameter int DW        = 64,
  parameter int FF_WORDS  = 8,
  parameter int RAM_WORDS = 4,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          pause,
  output logic          ff_se,
  output logic          ff_dir,
  output logic [DW-1:0] ff_sdi,
  input  logic [DW-1:0] ff_sdo,
  output logic          ram_se,
  output logic          ram_sd,
  output logic [DW-1:0] ram_sdi,
  input  logic [DW-1:0] ram_sdo,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_FF_SCAN, ST_RAM_SCAN} state_t;
  typedef enum logic [1:0] {OP_PAUSE, OP_RESUME, OP_SAVE, OP_LOAD} op_t;

  // Zero-length chains never enter their scan state, so the clamp only keeps the constant legal.
  localparam logic [CW-1:0] FF_LAST  = CW'((FF_WORDS  > 0) ? FF_WORDS  - 1 : 0);
  localparam logic [CW-1:0] RAM_LAST = CW'((RAM_WORDS > 0) ? RAM_WORDS - 1 : 0);

  state_t        state, state_n;
  logic          op_load, op_load_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pause_q, done_q, err_q;
  logic          done_n, err_n;
  logic          beat;
  op_t           op;

  assign op      = op_t'(cmd_op);
  assign pause   = pause_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ff_sdi  = in_data;
  assign ram_sdi = in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      op_load <= 1'b0;
      cnt     <= '0;
      pause_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      op_load <= op_load_n;
      cnt     <= cnt_n;
      pause_q <= (state_n != ST_RUN);
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_load_n = op_load;
    cnt_n     = cnt;
    done_n    = 1'b0;
    err_n     = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    beat      = 1'b0;
    ff_se     = 1'b0;
    ff_dir    = 1'b0;
    ram_se    = 1'b0;
    ram_sd    = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_data  = '0;

    case (state)
      ST_RUN: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op)
            OP_PAUSE:          state_n = ST_PAUSED;
            OP_SAVE, OP_LOAD:  err_n   = 1'b1;
            default:           state_n = ST_RUN;
          endcase
        end
      end

      ST_PAUSED: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op)
            OP_RESUME: state_n = ST_RUN;
            OP_SAVE, OP_LOAD: begin
              op_load_n = (op == OP_LOAD);
              cnt_n     = '0;
              if (FF_WORDS > 0)       state_n = ST_FF_SCAN;
              else if (RAM_WORDS > 0) state_n = ST_RAM_SCAN;
              else                    done_n  = 1'b1;
            end
            default: state_n = ST_PAUSED;
          endcase
        end
      end

      ST_FF_SCAN: begin
        busy      = 1'b1;
        out_valid = !op_load;
        in_ready  = op_load;
        beat      = op_load ? in_valid : out_ready;
        ff_se     = beat;
        ff_dir    = op_load;
        out_data  = ff_sdo;
        if (beat) begin
          if (cnt == FF_LAST) begin
            cnt_n = '0;
            if (RAM_WORDS > 0) begin
              state_n = ST_RAM_SCAN;
            end else begin
              state_n = ST_PAUSED;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      ST_RAM_SCAN: begin
        busy      = 1'b1;
        out_valid = !op_load;
        in_ready  = op_load;
        beat      = op_load ? in_valid : out_ready;
        ram_se    = beat;
        ram_sd    = op_load;
        out_data  = ram_sdo;
        if (beat) begin
          if (cnt == RAM_LAST) begin
            cnt_n   = '0;
            state_n = ST_PAUSED;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      default: state_n = ST_RUN;
    endcase
  end

endmodule
